// File: rtl/window_router_controller.sv
// Expands one output-pixel coordinate into the K x K input-window address stream,
// one kernel column per accepted beat, one kernel row per router lane.
module window_router_controller #(
    parameter int ROUTER_COUNT = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int STRIDE_WIDTH = 3
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_reg_clear,
    input  logic                                     i_start,
    input  logic [ADDR_WIDTH-1:0]                    i_o_x,
    input  logic [ADDR_WIDTH-1:0]                    i_o_y,
    input  logic [ADDR_WIDTH-1:0]                    i_i_size,
    input  logic [$clog2(ROUTER_COUNT+1)-1:0]        i_k_size,
    input  logic [STRIDE_WIDTH-1:0]                  i_stride,
    input  logic                                     i_ready,
    output logic [0:ROUTER_COUNT-1][ADDR_WIDTH-1:0]  o_x,
    output logic [0:ROUTER_COUNT-1][ADDR_WIDTH-1:0]  o_y,
    output logic [ROUTER_COUNT-1:0]                  o_lane_valid,
    output logic                                     o_valid,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_err
);

    localparam int KW = $clog2(ROUTER_COUNT + 1);
    localparam int CW = ADDR_WIDTH + STRIDE_WIDTH + 1;
    localparam logic [KW-1:0] K_MAX = KW'(ROUTER_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUTE,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [KW-1:0]   col_reg;
    logic [KW-1:0]   k_reg;
    logic [CW-1:0]   bx_reg;
    logic [CW-1:0]   by_reg;
    logic [CW-1:0]   size_reg;

    logic            start_bad;
    logic            load;
    logic            last_col;
    logic [CW-1:0]   start_bx;
    logic [CW-1:0]   start_by;
    logic [CW-1:0]   src_bx;
    logic [CW-1:0]   src_by;
    logic [CW-1:0]   src_size;
    logic [KW-1:0]   src_col;
    logic [KW-1:0]   src_k;
    logic [CW-1:0]   col_x;

    logic [0:ROUTER_COUNT-1][ADDR_WIDTH-1:0] x_next;
    logic [0:ROUTER_COUNT-1][ADDR_WIDTH-1:0] y_next;
    logic [ROUTER_COUNT-1:0]                 lane_valid_next;

    assign start_bad = (i_k_size == '0) || (i_k_size > K_MAX) || (i_stride == '0);
    assign load      = (state_reg == ST_IDLE) && i_start && !start_bad;
    assign last_col  = (col_reg == k_reg - KW'(1));

    assign start_bx  = CW'(i_o_x) * CW'(i_stride);
    assign start_by  = CW'(i_o_y) * CW'(i_stride);

    // The lane addresses for the next beat come either from the start inputs
    // (first beat) or from the latched window base with the column advanced.
    assign src_bx    = load ? start_bx : bx_reg;
    assign src_by    = load ? start_by : by_reg;
    assign src_size  = load ? CW'(i_i_size) : size_reg;
    assign src_k     = load ? i_k_size : k_reg;
    assign src_col   = load ? '0 : col_reg + KW'(1);
    assign col_x     = src_bx + CW'(src_col);

    genvar gi;
    generate
        for (gi = 0; gi < ROUTER_COUNT; gi++) begin : g_lane
            localparam logic [KW-1:0] LANE_IDX = KW'(gi);
            logic [CW-1:0] lane_y;
            logic          active;

            assign lane_y              = src_by + CW'(gi);
            assign active              = LANE_IDX < src_k;
            assign x_next[gi]          = active ? col_x[ADDR_WIDTH-1:0] : '0;
            assign y_next[gi]          = active ? lane_y[ADDR_WIDTH-1:0] : '0;
            assign lane_valid_next[gi] = active && (col_x < src_size) && (lane_y < src_size);
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            col_reg      <= '0;
            k_reg        <= '0;
            bx_reg       <= '0;
            by_reg       <= '0;
            size_reg     <= '0;
            o_x          <= '0;
            o_y          <= '0;
            o_lane_valid <= '0;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            if (i_reg_clear) begin
                state_reg    <= ST_IDLE;
                col_reg      <= '0;
                o_x          <= '0;
                o_y          <= '0;
                o_lane_valid <= '0;
                o_valid      <= 1'b0;
                o_busy       <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (start_bad) begin
                                o_err <= 1'b1;
                            end else begin
                                bx_reg       <= start_bx;
                                by_reg       <= start_by;
                                size_reg     <= CW'(i_i_size);
                                k_reg        <= i_k_size;
                                col_reg      <= '0;
                                o_x          <= x_next;
                                o_y          <= y_next;
                                o_lane_valid <= lane_valid_next;
                                o_valid      <= 1'b1;
                                o_busy       <= 1'b1;
                                state_reg    <= ST_ROUTE;
                            end
                        end
                    end
                    ST_ROUTE: begin
                        // o_valid is constantly high here, so acceptance is just i_ready.
                        if (i_ready) begin
                            if (last_col) begin
                                o_x          <= '0;
                                o_y          <= '0;
                                o_lane_valid <= '0;
                                o_valid      <= 1'b0;
                                o_done       <= 1'b1;
                                state_reg    <= ST_DONE;
                            end else begin
                                col_reg      <= src_col;
                                o_x          <= x_next;
                                o_y          <= y_next;
                                o_lane_valid <= lane_valid_next;
                            end
                        end
                    end
                    ST_DONE: begin
                        col_reg   <= '0;
                        o_busy    <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_window_router_controller.sv
// Self-checking bench for window_router_controller: directed cases from the
// feature list plus randomized windows checked against an arithmetic reference.
module tb_window_router_controller;

    localparam int RC = 4;
    localparam int AW = 8;
    localparam int SW = 3;
    localparam int KW = 3;

    logic                      i_clk = 1'b0;
    logic                      i_rst;
    logic                      i_reg_clear;
    logic                      i_start;
    logic [AW-1:0]             i_o_x;
    logic [AW-1:0]             i_o_y;
    logic [AW-1:0]             i_i_size;
    logic [KW-1:0]             i_k_size;
    logic [SW-1:0]             i_stride;
    logic                      i_ready;
    logic [0:RC-1][AW-1:0]     o_x;
    logic [0:RC-1][AW-1:0]     o_y;
    logic [RC-1:0]             o_lane_valid;
    logic                      o_valid;
    logic                      o_busy;
    logic                      o_done;
    logic                      o_err;

    int n_checks = 0;
    int n_fail   = 0;

    window_router_controller #(
        .ROUTER_COUNT(RC),
        .ADDR_WIDTH  (AW),
        .STRIDE_WIDTH(SW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_reg_clear (i_reg_clear),
        .i_start     (i_start),
        .i_o_x       (i_o_x),
        .i_o_y       (i_o_y),
        .i_i_size    (i_i_size),
        .i_k_size    (i_k_size),
        .i_stride    (i_stride),
        .i_ready     (i_ready),
        .o_x         (o_x),
        .o_y         (o_y),
        .o_lane_valid(o_lane_valid),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window geometry straight from the definition: lane r covers kernel row r,
    // beat c covers kernel column c, base is output coordinate times stride.
    function automatic void model_beat(input int ox, input int oy, input int sz, input int k,
                                       input int s, input int c,
                                       output logic [0:RC-1][AW-1:0] ex,
                                       output logic [0:RC-1][AW-1:0] ey,
                                       output logic [RC-1:0] em);
        ex = '0;
        ey = '0;
        em = '0;
        for (int r = 0; r < RC; r++) begin
            if (r < k) begin
                int x;
                int y;
                x = ox * s + c;
                y = oy * s + r;
                ex[r] = x[AW-1:0];
                ey[r] = y[AW-1:0];
                em[r] = (x < sz) && (y < sz);
            end
        end
    endfunction

    task automatic drive_start(input int ox, input int oy, input int sz, input int k, input int s);
        i_o_x    = AW'(ox);
        i_o_y    = AW'(oy);
        i_i_size = AW'(sz);
        i_k_size = KW'(k);
        i_stride = SW'(s);
        i_start  = 1'b1;
    endtask

    task automatic check_beat(input string tag, input logic [0:RC-1][AW-1:0] ex,
                              input logic [0:RC-1][AW-1:0] ey, input logic [RC-1:0] em);
        check({tag, " valid"}, 32'(o_valid), 32'd1);
        check({tag, " x"}, o_x, ex);
        check({tag, " y"}, o_y, ey);
        check({tag, " mask"}, 32'(o_lane_valid), 32'(em));
        check({tag, " busy"}, 32'(o_busy), 32'd1);
        check({tag, " done"}, 32'(o_done), 32'd0);
    endtask

    task automatic check_quiet(input string tag, input logic exp_busy, input logic exp_done);
        check({tag, " valid"}, 32'(o_valid), 32'd0);
        check({tag, " x"}, o_x, 32'd0);
        check({tag, " y"}, o_y, 32'd0);
        check({tag, " mask"}, 32'(o_lane_valid), 32'd0);
        check({tag, " busy"}, 32'(o_busy), 32'(exp_busy));
        check({tag, " done"}, 32'(o_done), 32'(exp_done));
        check({tag, " err"}, 32'(o_err), 32'd0);
    endtask

    // Runs one window; at beat stall_beat i_ready is held low for stall_n cycles.
    task automatic run_window(input string name, input int ox, input int oy, input int sz,
                              input int k, input int s, input int stall_beat, input int stall_n);
        logic [0:RC-1][AW-1:0] ex;
        logic [0:RC-1][AW-1:0] ey;
        logic [RC-1:0]         em;
        int                    hold;
        drive_start(ox, oy, sz, k, s);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int b = 0; b < k; b++) begin
            model_beat(ox, oy, sz, k, s, b, ex, ey, em);
            hold = (b == stall_beat) ? stall_n : 0;
            for (int h = 0; h <= hold; h++) begin
                check_beat($sformatf("%s b%0d h%0d", name, b, h), ex, ey, em);
                i_ready = (h < hold) ? 1'b0 : 1'b1;
                @(negedge i_clk);
            end
        end
        check_quiet({name, " done-cycle"}, 1'b1, 1'b1);
        @(negedge i_clk);
        check_quiet({name, " after"}, 1'b0, 1'b0);
        $display("%s: o=(%0d,%0d) size=%0d K=%0d S=%0d stall %0d at beat %0d",
                 name, ox, oy, sz, k, s, stall_n, stall_beat);
    endtask

    task automatic bad_start(input string name, input int k, input int s);
        drive_start(1, 1, 8, k, s);
        @(negedge i_clk);
        i_start = 1'b0;
        check({name, " err"}, 32'(o_err), 32'd1);
        check({name, " valid"}, 32'(o_valid), 32'd0);
        check({name, " busy"}, 32'(o_busy), 32'd0);
        @(negedge i_clk);
        check_quiet({name, " after"}, 1'b0, 1'b0);
        $display("%s: K=%0d S=%0d rejected", name, k, s);
    endtask

    initial begin
        logic [0:RC-1][AW-1:0] ex;
        logic [0:RC-1][AW-1:0] ey;
        logic [RC-1:0]         em;
        int ox, oy, sz, k, s, sb, sn;

        i_rst       = 1'b1;
        i_reg_clear = 1'b0;
        i_start     = 1'b0;
        i_o_x       = '0;
        i_o_y       = '0;
        i_i_size    = '0;
        i_k_size    = '0;
        i_stride    = '0;
        i_ready     = 1'b0;
        repeat (2) @(negedge i_clk);
        check_quiet("reset", 1'b0, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        $display("reset: outputs idle");

        run_window("basic", 0, 3, 5, 3, 1, -1, 0);
        run_window("stride", 1, 1, 8, 2, 2, -1, 0);
        run_window("backpressure", 0, 3, 5, 3, 1, 1, 2);
        run_window("right_pad", 2, 0, 5, 3, 2, -1, 0);

        bad_start("bad_k5", 5, 1);
        bad_start("bad_s0", 3, 0);
        bad_start("bad_k0", 0, 1);

        // Start while busy: ignored, no error, window keeps its latched geometry.
        model_beat(0, 3, 5, 3, 1, 0, ex, ey, em);
        drive_start(0, 3, 5, 3, 1);
        i_ready = 1'b0;
        @(negedge i_clk);
        drive_start(9, 9, 1, 5, 0);
        @(negedge i_clk);
        i_start = 1'b0;
        check("busy_start err", 32'(o_err), 32'd0);
        check_beat("busy_start hold", ex, ey, em);
        i_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            model_beat(0, 3, 5, 3, 1, b, ex, ey, em);
            check_beat($sformatf("busy_start b%0d", b), ex, ey, em);
            check($sformatf("busy_start b%0d err", b), 32'(o_err), 32'd0);
            @(negedge i_clk);
        end
        check_quiet("busy_start done-cycle", 1'b1, 1'b1);
        @(negedge i_clk);
        $display("busy_start: second start ignored");

        // Clear on beat 1 with a simultaneous start: clear wins, no done.
        drive_start(0, 3, 5, 3, 1);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        model_beat(0, 3, 5, 3, 1, 1, ex, ey, em);
        check_beat("clear beat1", ex, ey, em);
        i_reg_clear = 1'b1;
        drive_start(0, 3, 5, 3, 1);
        @(negedge i_clk);
        i_reg_clear = 1'b0;
        i_start     = 1'b0;
        check_quiet("clear next", 1'b0, 1'b0);
        @(negedge i_clk);
        check_quiet("clear after", 1'b0, 1'b0);
        $display("clear: aborted on beat 1");
        run_window("after_clear", 0, 3, 5, 3, 1, -1, 0);

        // Asynchronous reset mid-ROUTE clears outputs between edges.
        drive_start(2, 0, 5, 3, 2);
        i_ready = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        check("rst_mid pre valid", 32'(o_valid), 32'd1);
        #1 i_rst = 1'b1;
        #1;
        check_quiet("rst_mid async", 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        check_quiet("rst_mid after", 1'b0, 1'b0);
        $display("rst_mid: outputs cleared without clock edge");

        for (int t = 0; t < 24; t++) begin
            ox = $urandom_range(0, 12);
            oy = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) ox = $urandom_range(200, 255);
            if ($urandom_range(0, 3) == 0) oy = $urandom_range(200, 255);
            sz = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(1, 40);
            k  = $urandom_range(1, RC);
            s  = $urandom_range(1, 7);
            sb = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, k - 1);
            sn = $urandom_range(1, 3);
            run_window($sformatf("rand%0d", t), ox, oy, sz, k, s, sb, sn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/window_router_controller.md
# window_router_controller

Parametrised successor to the row router controller. It turns one output-pixel coordinate into the full K×K input-window address stream for a bank of row routers. Each router lane handles one kernel row. Lanes step across kernel columns one beat per accepted handshake. Kernel size and stride are set at run time, and right/bottom padding is flagged per lane. It sits between the convolution sequencer (upstream start) and the row routers / input buffer read ports (downstream valid/ready).

## Interface
Parameters:
- ROUTER_COUNT, 4: number of router lanes; also the maximum kernel size.
- ADDR_WIDTH, 8: coordinate width.
- STRIDE_WIDTH, 3: stride field width.

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_reg_clear  in  1  synchronous clear to IDLE; has priority over everything except i_rst.
- i_start  in  1  start request; sampled only in IDLE.
- i_o_x, i_o_y  in  ADDR_WIDTH  output-pixel coordinate, latched on accepted start.
- i_i_size  in  ADDR_WIDTH  input feature-map side length, latched on start.
- i_k_size  in  $clog2(ROUTER_COUNT+1)  kernel size K, latched on start.
- i_stride  in  STRIDE_WIDTH  stride S, latched on start.
- i_ready  in  1  downstream accepts the current beat.
- o_x, o_y  out  [0:ROUTER_COUNT-1][ADDR_WIDTH]  per-lane input coordinate.
- o_lane_valid  out  ROUTER_COUNT  per-lane valid; bit r is for lane r.
- o_valid  out  1  beat valid (the rr_en successor).
- o_busy  out  1  high in ROUTE and DONE.
- o_done  out  1  one-cycle pulse after the last beat is accepted.
- o_err  out  1  one-cycle pulse on a rejected start.

## Operation
States:
- **IDLE.** On i_start, check the parameters.
  - If K==0, K>ROUTER_COUNT, or S==0: pulse o_err next cycle and stay in IDLE.
  - Otherwise latch the inputs, compute bx=o_x·S and by=o_y·S, set col=0 and go to ROUTE.
- **ROUTE.** Hold o_valid=1.
  - For each lane r: o_y[r]=by+r and o_x[r]=bx+col.
  - Lane r is valid iff r<K, by+r<i_size and bx+col<i_size.
  - On o_valid&i_ready: if col==K-1 go to DONE, else increment col.
- **DONE.** Assert o_done for one cycle, then return to IDLE.

Arithmetic and width rules:
- Products and sums are computed at ADDR_WIDTH+STRIDE_WIDTH+1 bits.
- The range compare uses the full width.
- o_x/o_y are truncated to ADDR_WIDTH.
- Inactive lanes (r≥K) drive o_x=o_y=0.

Start and clear handling:
- i_start outside IDLE is ignored, with no o_err.
- i_reg_clear in any state: next cycle is IDLE, all outputs are 0, and no o_done is produced.
- i_reg_clear and i_start in the same cycle: the clear wins and the start is dropped.

Handshake and stall rules:
- While o_valid=1 and i_ready=0, all of o_x, o_y, o_lane_valid and o_valid hold stable.
- o_valid does not depend combinationally on i_ready.

## Timing
- Reset values: all outputs 0, state IDLE, col 0.
- Start accepted at edge t: o_valid=1 with col 0 from cycle t+1.
- With i_ready held high: exactly K beats; o_done is high in the cycle after the last beat; o_busy is high for K+1 cycles.
- Each low-i_ready cycle adds one cycle of latency.
- Back-to-back operation: a new start can be accepted in the cycle after o_done.
- Error path: o_err is high in the cycle after the rejected start; o_busy stays 0.
- Reset asserted mid-ROUTE: outputs go to 0 immediately, without waiting for a clock edge.

## Test plan
- **Basic window.** ROUTER_COUNT=4, ADDR_WIDTH=8; start with o=(0,3), size=5, K=3, S=1, ready=1.
  - Expect 3 beats with o_y lanes 0–2 = 3,4,5 and o_x = 0, 1, 2.
  - Expect o_lane_valid = 4'b0011 on every beat (lane2 y=5 is out of range, lane3 is inactive).
  - Expect o_done one cycle after the last beat.
- **Stride.** o=(1,1), size=8, K=2, S=2.
  - Expect beats with x=2 then x=3, y lanes 2,3, mask 4'b0011.
  - Expect o_busy high for exactly 3 cycles.
- **Backpressure.** Same setup as the basic window; drop i_ready for 2 cycles during beat 1.
  - Beat 1 outputs hold stable for 3 cycles.
  - Total beats = 3; o_done is delayed by 2 cycles.
- **Invalid start.**
  - K=5: one o_err pulse, no o_valid.
  - S=0: one o_err pulse, no o_valid.
  - i_start while busy: ignored, with no o_err.
- **Clear vs reset mid-operation.**
  - i_reg_clear on beat 1: IDLE next cycle, outputs 0, no o_done; a fresh start then yields a full K-beat sequence.
  - i_rst asserted mid-ROUTE: outputs are 0 before the next edge.
- **Right padding.** o=(2,0), size=5, K=3, S=2.
  - Beat x values are 4, 5, 6; mask = 4'b0111, then 0, then 0.
